logic_rule_prober: RTL

Sequential characterizer that drives the 3-input vector of a combinational rule module (in1, in2, in3) through all 8 combinations. For each combination it waits a settle window, samples the module's single output, and assembles the observed 8-bit truth-table code. It compares that code against an expected code and reports match plus a per-row mismatch mask. It sits beside a rule module in benches and on-chip self-test, acting as the stimulus-and-capture end of the rule-module interface.

---
 rtl/logic_rule_prober.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/logic_rule_prober.sv
// logic_rule_prober: sweeps a 3-input rule module through all 8 input
// vectors, samples its output after a settle window and reports the observed
// truth-table code against EXPECTED_CODE.
// Optional feature macro: STABILITY_CHECK_EN (double-sample each row and flag
// rows whose output moved during the last two settle cycles).
module logic_rule_prober #(
  parameter int          SETTLE_CYCLES = 4,
  parameter logic [7:0]  EXPECTED_CODE = 8'h6A
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic       dut_out,
  output logic [2:0] drive,
  output logic       busy,
  output logic       done,
  output logic [7:0] rule_code,
  output logic       match,
  output logic [7:0] mismatch_mask,
  output logic [7:0] unstable_mask
);

  localparam int CW = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CW-1:0] RELOAD = CW'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE_NEXT, DONE} state_t;

  // With a one-cycle window the counter is already 0 on load, so the row
  // goes straight to its sample cycle.
  localparam state_t FIRST = (SETTLE_CYCLES == 1) ? SAMPLE_NEXT : SETTLE;

  if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 65535) begin : g_bad_range
    $error("logic_rule_prober: SETTLE_CYCLES out of range 1..65535");
  end

  state_t        state;
  logic [CW-1:0] cnt;
  logic [7:0]    shadow;
  logic [7:0]    cap_code;
  logic [7:0]    cap_unst;

  // Shadow code with the row currently being sampled merged in.
  always_comb begin
    cap_code        = shadow;
    cap_code[drive] = dut_out;
  end

`ifdef STABILITY_CHECK_EN
  if (SETTLE_CYCLES < 2) begin : g_bad_settle
    $error("logic_rule_prober: STABILITY_CHECK_EN needs SETTLE_CYCLES >= 2");
  end

  logic       prev_s;
  logic [7:0] unst_sh;

  // Instability flags with the current row's comparison merged in.
  always_comb begin
    cap_unst        = unst_sh;
    cap_unst[drive] = (prev_s != dut_out);
  end

  // Early sample on the second-to-last settle cycle, flags collected per row.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_s  <= 1'b0;
      unst_sh <= 8'h00;
    end else if (state == IDLE && start) begin
      unst_sh <= 8'h00;
    end else if (!abort) begin
      if (state == SETTLE && cnt == CW'(1)) prev_s <= dut_out;
      if (state == SAMPLE_NEXT) unst_sh <= cap_unst;
    end
  end
`else
  assign cap_unst = 8'h00;
`endif

  // Sweep sequencer: settle, sample, advance, publish results on DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= '0;
      shadow        <= 8'h00;
      drive         <= 3'd0;
      busy          <= 1'b0;
      done          <= 1'b0;
      rule_code     <= 8'h00;
      match         <= 1'b0;
      mismatch_mask <= 8'h00;
      unstable_mask <= 8'h00;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            busy   <= 1'b1;
            drive  <= 3'd0;
            cnt    <= RELOAD;
            shadow <= 8'h00;
            state  <= FIRST;
          end
        end
        SETTLE: begin
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
            drive <= 3'd0;
            cnt   <= '0;
          end else begin
            cnt <= cnt - 1'b1;
            if (cnt == CW'(1)) state <= SAMPLE_NEXT;
          end
        end
        SAMPLE_NEXT: begin
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
            drive <= 3'd0;
            cnt   <= '0;
          end else begin
            shadow <= cap_code;
            if (drive == 3'd7) begin
              state         <= DONE;
              done          <= 1'b1;
              busy          <= 1'b0;
              drive         <= 3'd0;
              rule_code     <= cap_code;
              mismatch_mask <= cap_code ^ EXPECTED_CODE;
              unstable_mask <= cap_unst;
              match         <= (cap_code == EXPECTED_CODE) && (cap_unst == 8'h00);
            end else begin
              drive <= drive + 3'd1;
              cnt   <= RELOAD;
              state <= FIRST;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
